// File: rtl/nibble_serial_add_seq.sv
// Nibble-serial add/subtract sequencer. It drives an external 4-bit
// ripple-carry adder one nibble per clock, keeps the inter-nibble carry in a
// flop, and assembles the wide result. The FSM state is exported on dbg_state.
//
// Handshake: start is a single-cycle request that is taken only when the FSM
// is IDLE (busy=0). Requests made while busy are dropped, not queued. done is
// a one-cycle pulse, and sum/cout/ovf are valid in that cycle. They hold their
// value until the next accepted start.
module nibble_serial_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sub,
  input  logic                   cin,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   ovf,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_c0,
  input  logic [3:0]             add_s,
  input  logic                   add_c4,
  output logic [1:0]             dbg_state
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Bit offset of the current nibble. The operand registers are shifted
  // rather than part-selected, so no index can go out of range.
  logic [IDX_W+1:0] bit_ofs;
  logic [W-1:0]     a_sh;
  logic [W-1:0]     b_sh;

  assign bit_ofs = {idx_q, 2'b00};
  assign a_sh    = a_q >> bit_ofs;
  assign b_sh    = b_q >> bit_ofs;

  // Adder operand drive: the current nibble while running, zero otherwise.
  always_comb begin
    add_a  = 4'h0;
    add_b  = 4'h0;
    add_c0 = 1'b0;
    if (state_q == S_RUN) begin
      add_a  = a_sh[3:0];
      add_b  = b_sh[3:0];
      add_c0 = carry_q;
    end
  end

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = op_a;
          // Subtraction is A + ~B + 1. B is stored pre-inverted and the +1
          // enters as the initial carry.
          b_d     = sub ? ~op_b : op_b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d   = (sum_q & ~(W'(4'hF) << bit_ofs)) | (W'(add_s) << bit_ofs);
        carry_d = add_c4;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = add_c4;
          // Signed overflow: the operand signs agree (B after inversion) but
          // the result sign differs from them.
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_s[3] != a_q[W-1]);
          idx_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset. Reset aborts any
  // operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// Bench for nibble_serial_add_seq. It uses directed vectors with literal
// expectations, plus a whole-width arithmetic model that is compared against
// the outputs on every cycle.
module tb_nibble_serial_add_seq;

  localparam int N = 4;
  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT (NIBBLES=4) ----------------
  logic         start, sub, cin;
  logic [W-1:0] op_a, op_b;
  logic         busy, done, cout, ovf, add_c0, add_c4;
  logic [W-1:0] sum;
  logic [3:0]   add_a, add_b, add_s;
  logic [1:0]   dbg_state;

  // External 4-bit ripple-carry adder.
  assign {add_c4, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_c0);

  nibble_serial_add_seq #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .sum(sum),
    .cout(cout), .ovf(ovf), .add_a(add_a), .add_b(add_b), .add_c0(add_c0),
    .add_s(add_s), .add_c4(add_c4), .dbg_state(dbg_state)
  );

  // ---------------- DUT (NIBBLES=1) ----------------
  logic       start1, sub1, cin1;
  logic [3:0] op_a1, op_b1, sum1, add_a1, add_b1, add_s1;
  logic       busy1, done1, cout1, ovf1, add_c01, add_c41;
  logic [1:0] dbg_state1;

  assign {add_c41, add_s1} = 5'(add_a1) + 5'(add_b1) + 5'(add_c01);

  nibble_serial_add_seq #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .cin(cin1),
    .op_a(op_a1), .op_b(op_b1), .busy(busy1), .done(done1), .sum(sum1),
    .cout(cout1), .ovf(ovf1), .add_a(add_a1), .add_b(add_b1), .add_c0(add_c01),
    .add_s(add_s1), .add_c4(add_c41), .dbg_state(dbg_state1)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // cnt counts down the cycles remaining in an operation: N+1 at acceptance,
  // and 1 in the done cycle.
  logic [W+1:0] exp_q[$];          // {ovf, cout, sum} per accepted operation
  logic [W+1:0] hold;              // value the result outputs must show
  logic [W-1:0] cur_a, cur_b, m_bb;
  logic         cur_c, m_c, m_ov;
  logic [W:0]   m_full;
  int           cnt = 0;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      cnt = 0;
      hold = '0;
      exp_q.delete();
    end else if (cnt == 0) begin
      if (start) begin
        m_bb   = sub ? ~op_b : op_b;
        m_c    = sub ? 1'b1 : cin;
        m_full = {1'b0, op_a} + {1'b0, m_bb} + {{W{1'b0}}, m_c};
        m_ov   = (op_a[W-1] == m_bb[W-1]) && (m_full[W-1] != op_a[W-1]);
        exp_q.push_back({m_ov, m_full[W], m_full[W-1:0]});
        cur_a = op_a;
        cur_b = m_bb;
        cur_c = m_c;
        hold  = '0;
        cnt   = N + 1;
      end
    end else begin
      cnt = cnt - 1;
    end
  end

  // Compare process: checks every output on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      int idx;
      logic [31:0] low, e_a, e_b, e_c;
      if (done === 1'b1) done_cnt++;
      check("busy", busy, cnt > 0);
      check("done", done, cnt == 1);
      if (cnt == 1 && exp_q.size() > 0) hold = exp_q.pop_front();
      if (cnt <= 1) check("sum", sum, hold[W-1:0]);
      check("cout", cout, hold[W]);
      check("ovf", ovf, hold[W+1]);
      if (cnt >= 2) begin
        idx = N + 1 - cnt;
        low = (32'd1 << (4 * idx)) - 32'd1;
        e_a = (32'(cur_a) >> (4 * idx)) & 32'hF;
        e_b = (32'(cur_b) >> (4 * idx)) & 32'hF;
        e_c = (((32'(cur_a) & low) + (32'(cur_b) & low) + 32'(cur_c)) >> (4 * idx)) & 32'd1;
      end else begin
        e_a = 0; e_b = 0; e_c = 0;
      end
      check("add_a", add_a, e_a);
      check("add_b", add_b, e_b);
      check("add_c0", add_c0, e_c);
    end
  end

  // ---------------- driver tasks ----------------
  // Issues one operation and checks its result against literal values. It
  // also checks the done latency, the busy duration and the single-cycle done.
  task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic c, input logic [W-1:0] e_sum,
                       input logic e_cout, input logic e_ovf);
    int lat = 0;
    int busy_n = 0;
    bit seen = 1'b0;
    @(posedge clk); #1;
    op_a = a; op_b = b; sub = s; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin
        seen = 1'b1;
        lat = k;
        check({name, "_sum"}, sum, e_sum);
        check({name, "_cout"}, cout, e_cout);
        check({name, "_ovf"}, ovf, e_ovf);
      end
    end
    if (!seen) begin
      check({name, "_timeout"}, 0, 1);
    end else begin
      check({name, "_latency"}, lat, N + 1);
      check({name, "_busy_cycles"}, busy_n, N + 1);
      @(negedge clk);
      check({name, "_done_pulse"}, done, 1'b0);
      check({name, "_idle"}, busy, 1'b0);
      check({name, "_sum_hold"}, sum, e_sum);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    bit seen1;
    int lat1;
    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; op_a = '0; op_b = '0;
    start1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; op_a1 = '0; op_b1 = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum", sum, 16'h0000);
    check("rst_cout", cout, 1'b0);
    check("rst_add_a", add_a, 4'h0);
    check("rst_state", dbg_state, 2'd0);
    rst = 1'b0;

    do_op("add1", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("sub1", 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    do_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("cin", 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0);
    do_op("sub_cin_ignored", 16'h0010, 16'h0010, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

    // start held high with operands changing every cycle. Only starts seen
    // in IDLE are taken: 20 request edges give 4 operations.
    d0 = done_cnt;
    @(posedge clk); #1;
    op_a = 16'h0100; op_b = 16'h0010; sub = 1'b0; cin = 1'b0; start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      op_a = 16'(k * 16'h1111);
      op_b = 16'(k * 16'h0203);
      sub  = k[0];
    end
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("burst_done_count", done_cnt - d0, 4);

    // Reset in the third RUN cycle aborts the operation.
    @(posedge clk); #1;
    op_a = 16'hABCD; op_b = 16'h0001; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_sum", sum, 16'h0000);
    check("abort_add_b", add_b, 4'h0);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (6) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    do_op("after_abort", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

    // NIBBLES=1: a single RUN cycle, done two cycles after acceptance.
    @(posedge clk); #1;
    op_a1 = 4'h9; op_b1 = 4'h8; sub1 = 1'b0; cin1 = 1'b0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    seen1 = 1'b0;
    lat1 = 0;
    for (int k = 1; k <= 10 && !seen1; k++) begin
      @(negedge clk);
      if (done1 === 1'b1) begin
        seen1 = 1'b1;
        lat1 = k;
        check("n1_sum", sum1, 4'h1);
        check("n1_cout", cout1, 1'b1);
        check("n1_ovf", ovf1, 1'b1);
      end
    end
    if (!seen1) check("n1_timeout", 0, 1);
    else check("n1_latency", lat1, 2);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
